// File: rtl/md_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer; start -> hiloWr in WIDTH+2 cycles, or 2 for divide-by-zero.
// Holds the pipeline with stall while busy. Define MD_EARLY_OUT_EN to end a multiply once its remaining multiplier bits are all zero.
module md_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] regaData,
    input  logic [WIDTH-1:0] regbData,
    input  logic             flush,
    output logic             stall,
    output logic             hiloWr,
    output logic [WIDTH-1:0] hiData,
    output logic [WIDTH-1:0] loData
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops are MULT (00) and DIV (10): mdOp[0] clear.
    assign a_neg = ~mdOp[0] & regaData[WIDTH-1];
    assign b_neg = ~mdOp[0] & regbData[WIDTH-1];
    assign a_abs = a_neg ? -regaData : regaData;
    assign b_abs = b_neg ? -regbData : regbData;

    // Restoring divide: acc holds {remainder, dividend/quotient}; borrow out of rem_diff means restore.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mplier_q};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    assign stall  = ((state_q == IDLE) && start) || (state_q == CALC) || (state_q == FIX);
    assign hiloWr = (state_q == DONE);
    assign hiData = hi_q;
    assign loData = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = mdOp[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = mdOp[1] & a_neg;
                    cnt_d    = CW'(WIDTH);
                    mplier_d = b_abs;
                    dbz_d    = 1'b0;
                    state_d  = CALC;
                    if (mdOp[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                        mcand_d = '0;
                        if (regbData == '0) begin
                            dbz_d   = 1'b1;
                            acc_d   = {regaData, {WIDTH{1'b1}}};
                            state_d = FIX;
                        end
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, a_abs};
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (is_div_q) begin
                        if (!rem_diff[WIDTH]) begin
                            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Partial products are added pre-shifted, so no final alignment is needed.
                        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
`ifdef MD_EARLY_OUT_EN
                    if (!is_div_q && (mplier_q[WIDTH-1:1] == '0)) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (dbz_q) begin
                        hi_d = acc_q[2*WIDTH-1:WIDTH];
                        lo_d = acc_q[WIDTH-1:0];
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Randomized and directed bench for md_seq against a plain-arithmetic reference model.
module tb_md_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mdOp;
    logic [31:0] regaData;
    logic [31:0] regbData;
    logic        flush;
    logic        stall;
    logic        hiloWr;
    logic [31:0] hiData;
    logic [31:0] loData;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    md_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mdOp     (mdOp),
        .regaData (regaData),
        .regbData (regbData),
        .flush    (flush),
        .stall    (stall),
        .hiloWr   (hiloWr),
        .hiData   (hiData),
        .loData   (loData)
    );

    always #5 clk = ~clk;

    task automatic ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        logic [31:0] m;
        int hb;
        sa = $signed(a);
        sb = $signed(b);
        lat = 34;
        case (op)
            2'b00: begin sp = sa * sb; up = sp; hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFF_FFFF; lat = 2;
                end else if (op == 2'b10) begin
                    sq = sa / sb; sr = sa % sb; up = sq; lo = up[31:0]; up = sr; hi = up[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
`ifdef MD_EARLY_OUT_EN
        if (!op[1]) begin
            m = (op == 2'b00 && b[31]) ? -b : b;
            hb = -1;
            for (int i = 0; i < 32; i++) if (m[i]) hb = i;
            lat = (hb + 1 + 2 < 3) ? 3 : hb + 1 + 2;
        end
`else
        m = b;
        hb = 0;
`endif
    endtask

    // Runs one operation; flush_cyc / start2_cyc < 0 mean "not used".
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_cyc, input int start2_cyc);
        logic [31:0] exp_hi, exp_lo, got_hi, got_lo;
        int exp_lat, window, wr_cyc, wr_cnt, bad_cyc;
        bit flushed, exp_stall;
        ref_md(op, a, b, exp_hi, exp_lo, exp_lat);
        flushed = (flush_cyc >= 0) && (flush_cyc < exp_lat);
        window  = flushed ? flush_cyc + 4 : exp_lat + 2;
        wr_cyc  = -1;
        wr_cnt  = 0;
        bad_cyc = -1;
        got_hi  = '0;
        got_lo  = '0;
        for (int c = 0; c <= window; c++) begin
            @(posedge clk); #1;
            start    = (c == 0) || (c == start2_cyc);
            flush    = (c == flush_cyc);
            mdOp     = op;
            regaData = (c == 0) ? a : 32'h0000_0005;
            regbData = (c == 0) ? b : 32'h0000_0003;
            @(negedge clk);
            exp_stall = flushed ? (c <= flush_cyc) : (c < exp_lat);
            if (stall !== exp_stall && bad_cyc < 0) bad_cyc = c;
            if (hiloWr === 1'b1) begin
                wr_cnt++;
                if (wr_cyc < 0) begin wr_cyc = c; got_hi = hiData; got_lo = loData; end
            end
        end
        start = 1'b0;
        flush = 1'b0;

        n_total++;
        if (bad_cyc !== -1) $display("FAIL %s stall: first wrong at cycle %0d, expected clean trace", name, bad_cyc);
        else n_pass++;
        if (flushed) begin
            n_total++;
            if (wr_cnt !== 0) $display("FAIL %s no_write: hiloWr pulses %0d, expected 0", name, wr_cnt);
            else n_pass++;
            n_total++;
            if (hiData !== last_hi || loData !== last_lo)
                $display("FAIL %s retained: hi=%h lo=%h, expected hi=%h lo=%h", name, hiData, loData, last_hi, last_lo);
            else n_pass++;
        end else begin
            n_total++;
            if (wr_cyc !== exp_lat || wr_cnt !== 1)
                $display("FAIL %s latency: hiloWr at %0d (%0d pulses), expected at %0d once", name, wr_cyc, wr_cnt, exp_lat);
            else n_pass++;
            n_total++;
            if (got_hi !== exp_hi || got_lo !== exp_lo)
                $display("FAIL %s result: hi=%h lo=%h, expected hi=%h lo=%h", name, got_hi, got_lo, exp_hi, exp_lo);
            else n_pass++;
            n_total++;
            if (hiData !== exp_hi || loData !== exp_lo)
                $display("FAIL %s held: hi=%h lo=%h, expected hi=%h lo=%h", name, hiData, loData, exp_hi, exp_lo);
            else n_pass++;
            last_hi = exp_hi;
            last_lo = exp_lo;
        end
    endtask

    task automatic check_zero(input string name);
        n_total++;
        if (stall !== 1'b0 || hiloWr !== 1'b0 || hiData !== 32'h0 || loData !== 32'h0)
            $display("FAIL %s: stall=%b hiloWr=%b hi=%h lo=%h, expected all zero", name, stall, hiloWr, hiData, loData);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; flush = 1'b0; mdOp = 2'b00; regaData = '0; regbData = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero("post_reset_idle");
    endtask

    task automatic test_directed();
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, -1, -1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1);
        run_op("div_minneg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op("mult_minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op("early_out_case", 2'b01, 32'h0000_1234, 32'h0000_0003, -1, -1);
        run_op("mult_zero", 2'b01, 32'hDEAD_BEEF, 32'h0, -1, -1);
    endtask

    task automatic test_div_by_zero();
        run_op("divu_dbz", 2'b11, 32'h1234_5678, 32'h0, -1, 1);
        run_op("div_dbz_neg", 2'b10, 32'hFFFF_FF00, 32'h0, -1, -1);
    endtask

    task automatic test_flush();
        run_op("div_flush", 2'b10, 32'd100, 32'd7, 10, -1);
        run_op("divu_after_flush", 2'b11, 32'd100, 32'd7, -1, -1);
        run_op("flush_with_start", 2'b01, 32'd9, 32'd9, 0, -1);
        run_op("flush_in_fix", 2'b11, 32'd1000, 32'd3, 33, -1);
        run_op("flush_in_done", 2'b11, 32'd1000, 32'd3, 34, -1);
        run_op("start_while_busy", 2'b11, 32'd77, 32'd5, -1, 20);
    endtask

    task automatic test_reset_mid_op();
        @(posedge clk); #1;
        start = 1'b1; mdOp = 2'b01; regaData = 32'd5; regbData = 32'd3;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1 check_zero("reset_mid_op");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_hi = '0;
        last_lo = '0;
        run_op("multu_after_reset", 2'b01, 32'd5, 32'd3, -1, -1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(3, 0));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'h0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(255, 1));
                default: ;
            endcase
            run_op("random", op, a, b, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Multi-cycle multiply/divide sequencer sitting beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU operands from EX and runs an iterative shift-add multiplier or restoring divider for WIDTH cycles.
- Stalls the pipeline while busy, then delivers a one-cycle HI/LO write.
- Owns the only multiply/divide datapath; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request from EX; sampled only in IDLE.
- mdOp  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- regaData  in  WIDTH  multiplicand / dividend.
- regbData  in  WIDTH  multiplier / divisor.
- flush  in  1  synchronous abort of the in-flight operation.
- stall  out  1  hold IF/ID/EX.
- hiloWr  out  1  one-cycle HI/LO write strobe.
- hiData  out  WIDTH  MULT: product upper half; DIV: remainder.
- loData  out  WIDTH  MULT: product lower half; DIV: quotient.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; stall=0, hiloWr=0, hiData=0, loData=0; counter and working registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches operands and mdOp.
  - Signed ops (MULT, DIV) latch absolute values and record the result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - Counter is loaded with WIDTH; next state is CALC.
  - DIV/DIVU with regbData=0 go to FIX directly.
- CALC: one iteration per cycle, counter decrements; moves to FIX when the counter reaches 1 → 0.
  - Multiply: 2*WIDTH accumulator, shift-add on the LSB of the multiplier, unsigned.
  - Divide: restoring, shifting one dividend bit per cycle into the remainder; subtract if remainder >= divisor, quotient bit = 1.
- FIX: apply two's-complement negation per the recorded signs; next state DONE.
  - Divide-by-zero result: hiData=latched dividend (original, unsigned-reinterpreted), loData = all ones. No sign fix.
- DONE: hiloWr=1 for exactly this cycle; hiData/loData valid and held until the next start; next state IDLE.
- Latency: start at cycle 0 → hiloWr at cycle WIDTH+2 (cycle 34 for WIDTH=32). Divide-by-zero: hiloWr at cycle 2.
- stall is combinational: (state==IDLE & start) | state==CALC | state==FIX.
  - Deasserted in DONE so the stalled instruction retires alongside the HI/LO write.
- start while not IDLE: ignored, no queuing.
- flush=1 in CALC or FIX: next state IDLE, no hiloWr, hiData/loData unchanged.
  - flush in DONE: ignored; the write completes.
  - flush and start in the same IDLE cycle: flush wins, nothing starts.
- Asynchronous reset mid-operation: immediate IDLE, outputs zeroed, no hiloWr.
- Edge cases:
  - Most-negative / -1 for DIV: quotient wraps to the most-negative value, remainder 0.
  - Most-negative operands for MULT: correct 2*WIDTH result through the unsigned path.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: in multiply CALC, once the remaining unshifted multiplier bits are all zero, the accumulator is aligned in that cycle and the FSM goes straight to FIX. Latency becomes (index of highest set multiplier bit + 1) + 2, minimum 3 (multiplier 0). Divide is unchanged.
- Undefined: fixed WIDTH+2 latency for all non-zero-divisor operations.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at cycle 0 → stall=1 cycles 0–33; hiloWr=1 only at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=0xFFFFFFF9(-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678 b=0 → hiloWr at cycle 2, hi=0x12345678, lo=0xFFFFFFFF; a second start asserted at cycle 1 is ignored.
- DIV a=100 b=7, flush at cycle 10 → stall drops at cycle 11, no hiloWr; prior hi/lo retained; next DIVU 100/7 → lo=14, hi=2.
- MULTU 5*3 with rst pulled low at cycle 15 → all outputs 0 immediately, state IDLE; new op after release completes normally.
- With MD_EARLY_OUT_EN: MULTU 0x1234*0x3 → hiloWr at cycle 4, lo=0x369C, hi=0.
